// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction-fetch
// path and the load/store path of a single-cycle core. At most one access is
// issued per cycle. Contention alternates fairly. Read data returns one cycle
// after the grant, and the core stall is raised until both accesses of the
// current instruction have completed.
module mem_arbiter #(
  parameter  int MEM_WIDTH = 32,
  parameter  int MEM_SIZE  = 256,
  localparam int AW        = $clog2(MEM_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,          // asynchronous, active low

  // instruction-fetch side
  input  logic                 i_req,
  input  logic [AW-1:0]        i_addr,
  output logic                 i_gnt,
  output logic                 i_rvalid,
  output logic [MEM_WIDTH-1:0] i_rdata,

  // data (load/store) side
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [AW-1:0]        d_addr,
  input  logic [MEM_WIDTH-1:0] d_wdata,
  output logic                 d_gnt,
  output logic                 d_rvalid,
  output logic [MEM_WIDTH-1:0] d_rdata,

  // single-port memory
  output logic [AW-1:0]        mem_addr,
  output logic                 mem_read_en,
  output logic                 mem_write_en,
  output logic [MEM_WIDTH-1:0] mem_write_val,
  input  logic [MEM_WIDTH-1:0] mem_read_val,

  // core control
  output logic                 stall
);

  // Outstanding-read tracker: which side's read returns data this cycle.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD_I = 2'd1;
  localparam logic [1:0] RD_D = 2'd2;

  logic [1:0]           state_reg;
  logic [1:0]           state_next;
  logic                 token_reg;      // last granted side: 0 = instr, 1 = data
  logic                 token_next;
  logic [MEM_WIDTH-1:0] i_rdata_reg;
  logic [MEM_WIDTH-1:0] d_rdata_reg;

  // While reset is low every combinational output is forced quiet, so the
  // core and memory see no activity even between clock edges.
  logic run;
  assign run = reset;

  logic i_elig;
  logic d_elig;
  logic grant_i;
  logic grant_d;
  logic d_store;
  logic d_load;

  // A side whose read is completing this cycle cannot be re-granted; this is
  // what lets a fetch and a load overlap grant/return without idle cycles.
  assign i_elig = i_req && (state_reg != RD_I);
  assign d_elig = d_req && (state_reg != RD_D);

  // Arbitration: a lone eligible requester wins; under contention the side
  // opposite the last grant wins (token resets to data so fetch goes first).
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (run) begin
      if (i_elig && d_elig) begin
        grant_i = token_reg;
        grant_d = ~token_reg;
      end else begin
        grant_i = i_elig;
        grant_d = d_elig;
      end
    end
  end

  assign d_store = grant_d && d_we;
  assign d_load  = grant_d && !d_we;

  assign i_gnt = grant_i;
  assign d_gnt = grant_d;

  // Memory drive: address and strobes follow the granted side; quiet otherwise.
  always_comb begin
    mem_addr      = '0;
    mem_read_en   = 1'b0;
    mem_write_en  = 1'b0;
    mem_write_val = '0;
    if (grant_i) begin
      mem_addr    = i_addr;
      mem_read_en = 1'b1;
    end else if (grant_d) begin
      mem_addr = d_addr;
      if (d_we) begin
        mem_write_en  = 1'b1;
        mem_write_val = d_wdata;
      end else begin
        mem_read_en = 1'b1;
      end
    end
  end

  // Next state and token: a read grant records which side gets data next
  // cycle; a store completes immediately so it returns to IDLE.
  always_comb begin
    state_next = IDLE;
    token_next = token_reg;
    if (grant_i) begin
      state_next = RD_I;
      token_next = 1'b0;
    end else if (grant_d) begin
      state_next = d_load ? RD_D : IDLE;
      token_next = 1'b1;
    end
  end

  // Arbiter state; reset abandons any outstanding read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      token_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      token_reg <= token_next;
    end
  end

  // Completion: read data passes straight through in the return cycle and is
  // held afterwards until the same side's next completion.
  assign i_rvalid = run && (state_reg == RD_I);
  assign d_rvalid = run && (state_reg == RD_D);

  assign i_rdata = i_rvalid ? mem_read_val : i_rdata_reg;
  assign d_rdata = d_rvalid ? mem_read_val : d_rdata_reg;

  // Read-data holding registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_rdata_reg <= '0;
      d_rdata_reg <= '0;
    end else begin
      if (i_rvalid) i_rdata_reg <= mem_read_val;
      if (d_rvalid) d_rdata_reg <= mem_read_val;
    end
  end

  // Core stall: hold while a fetch has not returned or a data access has not
  // finished (a store finishes in its grant cycle).
  assign stall = run && ((i_req && !i_rvalid) ||
                         (d_req && !(d_rvalid || d_store)));

endmodule
